// File: rtl/rw_seq_pkg.sv
// rtl/rw_seq_pkg.sv - shared types and the round-robin pick for rw_spi_sequencer
// Contents:
//   state_t  sequencer states IDLE/SHIFT/DONE/GAP
//   gnt_t    which side owns the link for the current frame
//   rr_pick  chooses between simultaneous write/read requests
package rw_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        GAP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } gnt_t;

    // A lone requester always wins; on a tie pref_wr decides, and it points at
    // the side that was not served by the previous completed frame.
    function automatic gnt_t rr_pick(input logic wr, input logic rd, input logic pref_wr);
        gnt_t g;
        g = GNT_NONE;
        if (wr && (!rd || pref_wr)) begin
            g = GNT_WR;
        end else if (rd) begin
            g = GNT_RD;
        end
        return g;
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - tx/rx shift registers, sclk generator and bit counter for one frame
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             load load_data into tx shreg, clear counter, begin a frame
//   abort             drop the frame immediately: sclk=0, dout=0
//   load_data         word to transmit, MSB first
//   din               serial input, sampled on the cycle sclk rises
//   sclk, dout        serial clock (idles 0) and serial data out
//   done              high for the one cycle after the last sclk toggle
//   rx_data           received word (LSB shifted in)
module spi_shift_engine #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] load_data,
    input  logic              din,
    output logic              sclk,
    output logic              dout,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int CNT_W = $clog2(2*DATA_W+1);
    localparam logic [CNT_W-1:0] LAST_TOGGLE = CNT_W'(2*DATA_W);

    logic              active_q, active_d;
    logic              sclk_q,   sclk_d;
    logic              dout_q,   dout_d;
    logic [DATA_W-1:0] tx_q,     tx_d;
    logic [DATA_W-1:0] rx_q,     rx_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    // cnt_q counts sclk toggles already made; once it reaches 2*DATA_W sclk
    // is back at 0 and the frame is over.
    assign done = active_q && (cnt_q == LAST_TOGGLE);

    always_comb begin
        active_d = active_q;
        sclk_d   = sclk_q;
        dout_d   = dout_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        cnt_d    = cnt_q;
        if (start) begin
            active_d = 1'b1;
            sclk_d   = 1'b0;
            cnt_d    = '0;
            tx_d     = load_data;
            rx_d     = '0;
            dout_d   = load_data[DATA_W-1];
        end else if (abort || done) begin
            active_d = 1'b0;
            sclk_d   = 1'b0;
            dout_d   = 1'b0;
            cnt_d    = '0;
        end else if (active_q) begin
            sclk_d = ~sclk_q;
            cnt_d  = cnt_q + CNT_W'(1);
            if (!sclk_q) begin
                // rising edge of sclk: capture the slave's bit
                rx_d = {rx_q[DATA_W-2:0], din};
            end else begin
                // falling edge of sclk: present the next bit
                tx_d   = tx_q << 1;
                dout_d = tx_q[DATA_W-2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            dout_q   <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            dout_q   <= dout_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sclk    = sclk_q;
    assign dout    = dout_q;
    assign rx_data = rx_q;

endmodule

// File: rtl/rw_spi_sequencer.sv
// rtl/rw_spi_sequencer.sv - round-robin write/read sequencer sharing one SPI-style link
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ce                       enable; grants are only issued while ce=1
//   wr_req, wr_data, wr_ack  write request (level), payload, completion pulse
//   rd_req, rd_data, rd_ack  read request (level), captured data, completion pulse
//   load                     pulse alongside either ack
//   cs, sclk, dout, din      serial pins (cs active low, sclk idles 0)
//   busy                     high whenever the sequencer is not IDLE
// Build option: RW_SEQ_ABORT_EN - ce=0 during SHIFT abandons the frame
//   (no ack, pointer unchanged, request re-arbitrates later).
import rw_seq_pkg::*;

module rw_spi_sequencer #(
    parameter int DATA_W   = 8,
    parameter int IDLE_GAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_ack,
    output logic              load,
    output logic              cs,
    output logic              sclk,
    output logic              dout,
    input  logic              din,
    output logic              busy
);

    localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(IDLE_GAP - 1);

    state_t            state_q,   state_d;
    gnt_t              gnt_q,     gnt_d;
    logic              pref_wr_q, pref_wr_d;
    logic [GAP_W-1:0]  gap_q,     gap_d;
    logic              wr_ack_q,  wr_ack_d;
    logic              rd_ack_q,  rd_ack_d;
    logic              load_q,    load_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              cs_q,      cs_d;
    logic              busy_q,    busy_d;

    logic              eng_start;
    logic              eng_abort;
    logic [DATA_W-1:0] eng_load_data;
    logic              eng_done;
    logic [DATA_W-1:0] eng_rx;
    logic              abort_req;

`ifdef RW_SEQ_ABORT_EN
    assign abort_req = (state_q == SHIFT) && !ce;
`else
    assign abort_req = 1'b0;
`endif

    spi_shift_engine #(
        .DATA_W (DATA_W)
    ) u_engine (
        .clk       (clk),
        .rst       (rst),
        .start     (eng_start),
        .abort     (eng_abort),
        .load_data (eng_load_data),
        .din       (din),
        .sclk      (sclk),
        .dout      (dout),
        .done      (eng_done),
        .rx_data   (eng_rx)
    );

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        pref_wr_d     = pref_wr_q;
        gap_d         = gap_q;
        wr_ack_d      = 1'b0;
        rd_ack_d      = 1'b0;
        load_d        = 1'b0;
        rd_data_d     = rd_data_q;
        eng_start     = 1'b0;
        eng_abort     = 1'b0;
        eng_load_data = '0;

        case (state_q)
            IDLE: begin
                if (ce && (wr_req || rd_req)) begin
                    gnt_d     = rr_pick(wr_req, rd_req, pref_wr_q);
                    eng_start = 1'b1;
                    // reads shift out zeros
                    eng_load_data = (gnt_d == GNT_WR) ? wr_data : '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (abort_req) begin
                    // frame dropped: pointer untouched so the same side wins again
                    eng_abort = 1'b1;
                    gnt_d     = GNT_NONE;
                    gap_d     = GAP_INIT;
                    state_d   = GAP;
                end else if (eng_done) begin
                    load_d = 1'b1;
                    if (gnt_q == GNT_WR) begin
                        wr_ack_d = 1'b1;
                    end else begin
                        rd_ack_d  = 1'b1;
                        rd_data_d = eng_rx;
                    end
                    pref_wr_d = (gnt_q == GNT_RD);
                    state_d   = DONE;
                end
            end
            DONE: begin
                gnt_d   = GNT_NONE;
                gap_d   = GAP_INIT;
                state_d = GAP;
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // registered pin/status decode of the next state keeps cs and busy glitch free
        cs_d   = (state_d != SHIFT);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= GNT_NONE;
            pref_wr_q <= 1'b1;
            gap_q     <= '0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            load_q    <= 1'b0;
            rd_data_q <= '0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            pref_wr_q <= pref_wr_d;
            gap_q     <= gap_d;
            wr_ack_q  <= wr_ack_d;
            rd_ack_q  <= rd_ack_d;
            load_q    <= load_d;
            rd_data_q <= rd_data_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_ack  = wr_ack_q;
    assign rd_ack  = rd_ack_q;
    assign load    = load_q;
    assign rd_data = rd_data_q;
    assign cs      = cs_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_rw_spi_sequencer.sv
// tb/tb_rw_spi_sequencer.sv - self-checking bench for rw_spi_sequencer
module tb_rw_spi_sequencer;

    localparam int IDLE_GAP = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b0;
    logic       wr_req = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ack;
    logic       rd_req = 1'b0;
    logic [7:0] rd_data;
    logic       rd_ack;
    logic       load;
    logic       cs;
    logic       sclk;
    logic       dout;
    logic       din = 1'b0;
    logic       busy;

    logic [7:0] din_pat = 8'h00;
    int         tests = 0;
    int         fails = 0;

    rw_spi_sequencer #(
        .DATA_W   (8),
        .IDLE_GAP (IDLE_GAP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .wr_req  (wr_req),
        .wr_data (wr_data),
        .wr_ack  (wr_ack),
        .rd_req  (rd_req),
        .rd_data (rd_data),
        .rd_ack  (rd_ack),
        .load    (load),
        .cs      (cs),
        .sclk    (sclk),
        .dout    (dout),
        .din     (din),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Slave: presents din_pat MSB first, one bit per sclk rise.
    initial begin : slave
        int r;
        logic ps;
        r = 0;
        ps = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (cs === 1'b1) r = 0;
            else if (sclk === 1'b1 && ps === 1'b0) r++;
            ps = sclk;
            din = (r < 8) ? din_pat[7-r] : 1'b0;
        end
    end

    // Frame-level model: every frame must start with cs falling on a real request,
    // run 16 sclk toggles shifting the expected word, and end 17 samples later with
    // the ack of the side round-robin says should have won.
    initial begin : monitor
        logic p_cs, p_sclk, p_wr, p_rd, p_ce;
        logic [7:0] p_wdata, bits, exp_bits;
        logic in_frame, exp_wr, had_frame, pref_wr;
        int t_fall, toggles, hi_run, mcyc;
        p_cs = 1'b1; p_sclk = 1'b0; p_wr = 1'b0; p_rd = 1'b0; p_ce = 1'b0;
        p_wdata = 8'h00; bits = 8'h00; exp_bits = 8'h00;
        in_frame = 1'b0; exp_wr = 1'b0; had_frame = 1'b0; pref_wr = 1'b1;
        t_fall = 0; toggles = 0; hi_run = 0; mcyc = 0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (rst) begin
                in_frame = 1'b0;
                had_frame = 1'b0;
                pref_wr = 1'b1;
                hi_run = 0;
            end else begin
                check("ack_overlap", {31'd0, wr_ack & rd_ack}, 0);
                check("load_eq_ack", {31'd0, load}, {31'd0, wr_ack | rd_ack});
                if (!in_frame) check("ack_outside_frame", {30'd0, wr_ack, rd_ack}, 0);
                if (p_cs && !cs) begin
                    check("grant_has_req", {31'd0, p_wr | p_rd}, 1);
                    if (had_frame) check("gap_len", {31'd0, hi_run >= IDLE_GAP + 1}, 1);
                    check("start_sclk_low", {31'd0, sclk}, 0);
                    exp_wr   = p_wr && (!p_rd || pref_wr);
                    exp_bits = exp_wr ? p_wdata : 8'h00;
                    in_frame = 1'b1;
                    t_fall   = mcyc;
                    toggles  = 0;
                    bits     = 8'h00;
                end else if (in_frame && !cs) begin
                    if (sclk != p_sclk) toggles++;
                    if (sclk && !p_sclk) bits = {bits[6:0], dout};
                end else if (in_frame && cs) begin
                    if (wr_ack || rd_ack) begin
                        check("ack_side", {30'd0, wr_ack, rd_ack}, exp_wr ? 2 : 1);
                        check("ack_latency", mcyc - t_fall, 17);
                        check("sclk_toggles", toggles, 16);
                        check("dout_bits", {24'd0, bits}, {24'd0, exp_bits});
                        check("done_sclk_dout", {30'd0, sclk, dout}, 0);
                        if (rd_ack) check("rd_data", {24'd0, rd_data}, {24'd0, din_pat});
                        pref_wr = !exp_wr;
                    end else begin
`ifdef RW_SEQ_ABORT_EN
                        check("abort_needs_ce0", {31'd0, p_ce}, 0);
                        check("abort_sclk_dout", {30'd0, sclk, dout}, 0);
`else
                        check("ack_at_cs_rise", {31'd0, wr_ack | rd_ack}, 1);
`endif
                    end
                    in_frame = 1'b0;
                    had_frame = 1'b1;
                end
                if (cs) hi_run++;
                else hi_run = 0;
            end
            p_cs = cs; p_sclk = sclk; p_wr = wr_req; p_rd = rd_req; p_ce = ce; p_wdata = wr_data;
        end
    end

    // Runs cycles until an ack appears, collecting the bits seen on sclk rises.
    task automatic run_until_ack(output logic [1:0] acks, output logic [7:0] bits,
                                 output int toggles, output int n);
        logic ps;
        ps = sclk;
        bits = 8'h00;
        toggles = 0;
        n = 0;
        do begin
            step(1);
            n++;
            if (sclk != ps) toggles++;
            if (sclk && !ps) bits = {bits[6:0], dout};
            ps = sclk;
        end while (!(wr_ack || rd_ack) && n < 200);
        acks = {wr_ack, rd_ack};
        check("ack_seen", {31'd0, wr_ack | rd_ack}, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        ce = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
    endtask

    task automatic wait_toggles(input int k);
        int t, n;
        logic ps;
        t = 0; n = 0; ps = sclk;
        while (t < k && n < 60) begin
            step(1);
            n++;
            if (sclk != ps) t++;
            ps = sclk;
        end
        check("toggle_wait", t, k);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin : stim
        logic [1:0] acks;
        logic [7:0] bits;
        int toggles, n, cnt;

        // reset state
        step(3);
        check("rst_cs", {31'd0, cs}, 1);
        check("rst_sclk_dout", {30'd0, sclk, dout}, 0);
        check("rst_acks_load", {29'd0, wr_ack, rd_ack, load}, 0);
        check("rst_rd_data", {24'd0, rd_data}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        ce = 1'b1;
        step(1);

        // 1) write A5
        wr_data = 8'hA5;
        wr_req = 1'b1;
        run_until_ack(acks, bits, toggles, n);
        check("t1_acks", {30'd0, acks}, 2);
        check("t1_bits", {24'd0, bits}, 32'hA5);
        check("t1_toggles", toggles, 16);
        check("t1_latency", n, 18);
        check("t1_load_cs", {30'd0, load, cs}, 3);
        wr_req = 1'b0;
        step(4);

        // 2) read 3C
        do_reset();
        din_pat = 8'h3C;
        rd_req = 1'b1;
        run_until_ack(acks, bits, toggles, n);
        check("t2_acks", {30'd0, acks}, 1);
        check("t2_rd_data", {24'd0, rd_data}, 32'h3C);
        check("t2_dout_zero", {24'd0, bits}, 0);
        check("t2_latency", n, 18);
        check("t2_load", {31'd0, load}, 1);
        rd_req = 1'b0;
        step(4);

        // 3) both held from reset: W,R,W,R
        rst = 1'b1;
        ce = 1'b1;
        wr_data = 8'h5A;
        din_pat = 8'hE1;
        wr_req = 1'b1;
        rd_req = 1'b1;
        step(2);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            run_until_ack(acks, bits, toggles, n);
            check("t3_order", {30'd0, acks}, (k % 2 == 0) ? 2 : 1);
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        step(4);

        // 4) ce=0 holds off grants
        rst = 1'b1;
        ce = 1'b0;
        wr_req = 1'b1;
        rd_req = 1'b1;
        step(2);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            check("t4_idle_cs_busy", {30'd0, cs, busy}, 2);
        end
        ce = 1'b1;
        step(1);
        check("t4_cs_falls", {30'd0, cs, busy}, 1);
        run_until_ack(acks, bits, toggles, n);
        check("t4_first_wr", {30'd0, acks}, 2);
        wr_req = 1'b0;
        run_until_ack(acks, bits, toggles, n);
        check("t4_then_rd", {30'd0, acks}, 1);
        rd_req = 1'b0;
        step(4);

        // 5) reset mid-frame after 5th toggle
        do_reset();
        wr_data = 8'hC3;
        wr_req = 1'b1;
        wait_toggles(5);
        rst = 1'b1;
        step(1);
        check("t5_after_rst", {28'd0, cs, sclk, dout, busy}, 32'h8);
        rst = 1'b0;
        wr_req = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (wr_ack || rd_ack || load) cnt++;
        end
        check("t5_no_ack", cnt, 0);

`ifdef RW_SEQ_ABORT_EN
        // 6) abort with ce=0 at 6th toggle, then regrant the same writer
        do_reset();
        wr_data = 8'h96;
        wr_req = 1'b1;
        wait_toggles(6);
        ce = 1'b0;
        step(1);
        check("t6_abort", {28'd0, cs, sclk, wr_ack, load}, 32'h8);
        step(3);
        ce = 1'b1;
        run_until_ack(acks, bits, toggles, n);
        check("t6_regrant", {30'd0, acks}, 2);
        check("t6_bits", {24'd0, bits}, 32'h96);
        wr_req = 1'b0;
        step(4);
`else
        // ce dropped mid-frame is ignored: frame completes
        do_reset();
        wr_data = 8'h69;
        wr_req = 1'b1;
        wait_toggles(6);
        ce = 1'b0;
        run_until_ack(acks, bits, toggles, n);
        check("t6_ce_ignored", {30'd0, acks}, 2);
        wr_req = 1'b0;
        step(4);
        check("t6_idle_no_grant", {30'd0, cs, busy}, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
